// File: rtl/io_bus_pkg.sv
// Shared constants for the memory-mapped I/O port bus: port addresses, default widths,
// request opcodes and the bus-master state encoding.
package io_bus_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 11;

  // The I/O port block decodes against these same two addresses.
  localparam logic [10:0] IN_PORT_ADDR  = 11'h0FE;
  localparam logic [10:0] OUT_PORT_ADDR = 11'h0FF;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ADDR   = 3'd1,
    RD_SAMPLE = 3'd2,
    WR        = 3'd3,
    RESP      = 3'd4
  } io_bus_state_e;

endpackage

// File: rtl/io_addr_decode.sv
// Combinational legality check of a request's op and address against the port map.
// Poll is legal only when IO_BUS_MASTER_POLL_EN is defined.
module io_addr_decode
  import io_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  output logic              legal
);

  logic is_in_port;
  logic is_out_port;

  assign is_in_port  = (addr == ADDR_W'(IN_PORT_ADDR));
  assign is_out_port = (addr == ADDR_W'(OUT_PORT_ADDR));

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_READ:  legal = is_in_port;
      OP_WRITE: legal = is_out_port;
`ifdef IO_BUS_MASTER_POLL_EN
      OP_POLL:  legal = is_in_port;
`else
      OP_POLL:  legal = 1'b0;
`endif
      OP_RSVD:  legal = 1'b0;
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/io_bus_master.sv
// Bus initiator turning read/write/poll requests into registered read_en/write_en bus cycles.
// Define IO_BUS_MASTER_POLL_EN to support the poll op and its attempt counter.
module io_bus_master
  import io_bus_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int POLL_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  // Request handshake: a request transfers on the rising edge where req_valid && req_ready.
  // req_ready is high only in IDLE; req_valid while not ready is dropped, not queued.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_mask,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              read_en,
  output logic              write_en,
  output logic [ADDR_W-1:0] in_addr,
  output logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] out_data,
  output logic [2:0]        dbg_state
);

  io_bus_state_e     state_q, state_d;
  logic              ready_q, ready_d;
  logic              read_en_q, read_en_d;
  logic              write_en_q, write_en_d;
  logic [ADDR_W-1:0] in_addr_q, in_addr_d;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
  logic              legal;

  io_addr_decode #(.ADDR_W(ADDR_W)) u_decode (
    .op    (req_op),
    .addr  (req_addr),
    .legal (legal)
  );

`ifdef IO_BUS_MASTER_POLL_EN
  localparam int CNT_W = $clog2(POLL_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(POLL_TIMEOUT);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              poll_q, poll_d;
  logic [DATA_W-1:0] match_q, match_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic              poll_hit;
  logic              last_try;

  assign poll_hit = ((out_data & mask_q) == (match_q & mask_q));
  // The sample being judged is attempt cnt_q+1; the last one allowed is attempt POLL_TIMEOUT.
  assign last_try = (cnt_q >= CNT_MAX - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      poll_q  <= 1'b0;
      match_q <= '0;
      mask_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      match_q <= match_d;
      mask_q  <= mask_d;
    end
  end
`else
  logic unused_poll;
  assign unused_poll = ^{req_mask, 32'(POLL_TIMEOUT)};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      read_en_q    <= 1'b0;
      write_en_q   <= 1'b0;
      in_addr_q    <= '0;
      in_data_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      read_en_q    <= read_en_d;
      write_en_q   <= write_en_d;
      in_addr_q    <= in_addr_d;
      in_data_q    <= in_data_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Every output is computed for the state being entered, so strobes line up with their state.
  always_comb begin
    state_d      = state_q;
    read_en_d    = 1'b0;
    write_en_d   = 1'b0;
    in_addr_d    = in_addr_q;
    in_data_d    = in_data_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
`ifdef IO_BUS_MASTER_POLL_EN
    cnt_d        = cnt_q;
    poll_d       = poll_q;
    match_d      = match_q;
    mask_d       = mask_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!legal) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = '0;
          end else if (req_op == OP_WRITE) begin
            state_d    = WR;
            write_en_d = 1'b1;
            in_addr_d  = req_addr;
            in_data_d  = req_wdata;
          end else begin
            state_d   = RD_ADDR;
            read_en_d = 1'b1;
            in_addr_d = req_addr;
`ifdef IO_BUS_MASTER_POLL_EN
            cnt_d   = '0;
            poll_d  = (req_op == OP_POLL);
            match_d = req_wdata;
            mask_d  = req_mask;
`endif
          end
        end
      end

      RD_ADDR: state_d = RD_SAMPLE;

      RD_SAMPLE: begin
        resp_data_d = out_data;
`ifdef IO_BUS_MASTER_POLL_EN
        if (poll_q && !poll_hit) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          if (last_try) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d   = RD_ADDR;
            read_en_d = 1'b1;
          end
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
        end
`else
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
`endif
      end

      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_data_d  = '0;
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  assign req_ready  = ready_q;
  assign read_en    = read_en_q;
  assign write_en   = write_en_q;
  assign in_addr    = in_addr_q;
  assign in_data    = in_data_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master with a behavioural I/O port block and a per-request reference model.
// Poll expectations follow IO_BUS_MASTER_POLL_EN when it is defined.
module tb_io_bus_master;

  localparam int DW      = 4;
  localparam int AW      = 11;
  localparam int TIMEOUT = 4;
  localparam int W       = DW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] req_mask = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic          read_en;
  logic          write_en;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic [DW-1:0] out_data = '0;
  logic [2:0]    dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  // Port block stand-in: read_en latches the next value of the in_port sequence.
  logic [DW-1:0] in_seq [8];
  logic [DW-1:0] out_port = '0;
  int            rd_cnt = 0;
  int            seq_base = 0;

  io_bus_master #(.DATA_W(DW), .ADDR_W(AW), .POLL_TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_mask   (req_mask),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .read_en    (read_en),
    .write_en   (write_en),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .out_data   (out_data),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] seq_at(input int k);
    return in_seq[(k > 7) ? 7 : k];
  endfunction

  always @(posedge clk) begin
    if (read_en) begin
      out_data <= seq_at(rd_cnt - seq_base);
      rd_cnt   <= rd_cnt + 1;
    end
    if (write_en) out_port <= in_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_seq(input logic [DW-1:0] v);
    for (int i = 0; i < 8; i++) in_seq[i] = v;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the response.
  task automatic run_req(input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] mk);
    logic          legal;
    logic          found;
    int            exp_lat, exp_rd, exp_wr;
    logic          exp_err;
    logic [DW-1:0] exp_data;
    int            lat, nrd, nwr, both;
    logic [DW-1:0] wr_seen;
    logic [AW-1:0] addr_seen;
    logic [DW-1:0] port_before;
    logic [W-1:0]  want;

    legal = (op == 2'd0 && addr == 11'h0FE) || (op == 2'd1 && addr == 11'h0FF);
`ifdef IO_BUS_MASTER_POLL_EN
    legal = legal || (op == 2'd2 && addr == 11'h0FE);
`endif
    exp_rd = 0; exp_wr = 0; exp_err = 1'b0; exp_data = '0;
    if (!legal) begin
      exp_lat = 1; exp_err = 1'b1;
    end else if (op == 2'd1) begin
      exp_lat = 2; exp_wr = 1;
    end else if (op == 2'd0) begin
      exp_lat = 3; exp_rd = 1; exp_data = seq_at(0);
    end else begin
      found = 1'b0;
      exp_rd = TIMEOUT; exp_err = 1'b1; exp_data = seq_at(TIMEOUT - 1);
      for (int k = 0; k < TIMEOUT; k++) begin
        if (!found && (((seq_at(k) ^ wd) & mk) == '0)) begin
          found = 1'b1; exp_rd = k + 1; exp_err = 1'b0; exp_data = seq_at(k);
        end
      end
      exp_lat = 1 + 2 * exp_rd;
    end
    exp_q.push_back({exp_err, exp_data});

    seq_base = rd_cnt;
    port_before = out_port;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_mask = mk;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_wdata = DW'($urandom); req_mask = DW'($urandom);

    lat = 0; nrd = 0; nwr = 0; both = 0; wr_seen = '0; addr_seen = '0;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) check("busy_ready", req_ready, 0);
      if (read_en && write_en) both++;
      if (read_en) begin nrd++; addr_seen = in_addr; end
      if (write_en) begin nwr++; wr_seen = in_data; addr_seen = in_addr; end
      if (resp_valid) lat = c;
    end
    want = exp_q.pop_front();
    check("latency", lat, exp_lat);
    check("resp_err", resp_err, want[W-1]);
    check("resp_data", resp_data, want[DW-1:0]);
    check("read_strobes", nrd, exp_rd);
    check("write_strobes", nwr, exp_wr);
    check("strobe_overlap", both, 0);
    if (exp_wr != 0) begin
      check("wr_data", wr_seen, wd);
      check("out_port", out_port, wd);
    end else begin
      check("out_port_hold", out_port, port_before);
    end
    if (exp_rd != 0 || exp_wr != 0) check("bus_addr", addr_seen, addr);
    @(negedge clk);
    check("resp_pulse", resp_valid, 0);
    check("ready_back", req_ready, 1);
  endtask

  initial begin
    logic [1:0]    r_op;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wd, r_mk;
    int            sel;

    fill_seq('0);
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_read_en", read_en, 0);
    check("rst_write_en", write_en, 0);
    check("rst_in_addr", in_addr, 0);
    check("rst_in_data", in_data, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_err", resp_err, 0);
    rst = 1'b0;
    @(negedge clk);

    run_req(2'd1, 11'h0FF, 4'hC, 4'h0);
    fill_seq(4'hC);
    run_req(2'd0, 11'h0FE, 4'h0, 4'h0);
    fill_seq(4'h1);
    run_req(2'd0, 11'h0FE, 4'h0, 4'h0);
    run_req(2'd0, 11'h0F8, 4'h0, 4'h0);
    run_req(2'd1, 11'h0BF, 4'hF, 4'h0);
    check("out_port_kept", out_port, 4'hC);

    fill_seq(4'h0);
    in_seq[3] = 4'h9; in_seq[4] = 4'h9;
    run_req(2'd2, 11'h0FE, 4'h8, 4'h8);
    fill_seq(4'h0);
    run_req(2'd2, 11'h0FE, 4'h8, 4'h8);
    run_req(2'd3, 11'h0FE, 4'h0, 4'h0);
    run_req(2'd0, 11'h0FF, 4'h0, 4'h0);
    run_req(2'd1, 11'h0FE, 4'h3, 4'h0);

    // Abort a read while its sample is being taken.
    fill_seq(4'h5);
    req_valid = 1'b1; req_op = 2'd0; req_addr = 11'h0FE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy", req_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_read_en", read_en, 0);
    check("abort_write_en", write_en, 0);
    check("abort_resp", resp_valid, 0);
    check("abort_ready", req_ready, 1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_resp", resp_valid, 0);
    end
    fill_seq(4'h6);
    run_req(2'd0, 11'h0FE, 4'h0, 4'h0);

    for (int t = 0; t < 40; t++) begin
      r_op = 2'($urandom_range(0, 3));
      sel  = $urandom_range(0, 3);
      r_addr = (sel == 0) ? 11'h0FE : (sel == 1) ? 11'h0FF : AW'($urandom);
      r_wd = DW'($urandom);
      r_mk = DW'($urandom);
      for (int i = 0; i < 8; i++) in_seq[i] = DW'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        sel = $urandom_range(0, 5);
        in_seq[sel] = (r_wd & r_mk) | (in_seq[sel] & ~r_mk);
      end
      run_req(r_op, r_addr, r_wd, r_mk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_bus_master.md
# io_bus_master

Bus initiator for the memory-mapped I/O port block. Accepts read, write and poll requests on a valid/ready request interface and turns them into correctly timed `read_en`/`write_en`/`in_addr`/`in_data` bus cycles. Captures the registered `out_data` response and returns one response per request. Sits between the control sequencer and the I/O port block, on the initiator side of the bus.

## Interface
Parameters:
- `DATA_W`, 4: bus and port data width.
- `ADDR_W`, 11: bus address width.
- `POLL_TIMEOUT`, 255: maximum read attempts per poll request; minimum 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `req_op`  in  2  request type: 00 read, 01 write, 10 poll, 11 reserved.
- `req_addr`  in  ADDR_W  target port address.
- `req_wdata`  in  DATA_W  write data, or poll match value.
- `req_mask`  in  DATA_W  poll bit mask; ignored for read and write.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_data`  out  DATA_W  read or poll data; 0 for write and error.
- `resp_err`  out  1  qualifies `resp_valid`: unmapped, illegal or timed-out request.
- `read_en`  out  1  bus read strobe to the port block.
- `write_en`  out  1  bus write strobe to the port block.
- `in_addr`  out  ADDR_W  bus address.
- `in_data`  out  DATA_W  bus write data.
- `out_data`  in  DATA_W  registered read data from the port block.

## Operation
- States: IDLE, RD_ADDR, RD_SAMPLE, WR, RESP.
- A request is accepted on the edge where `req_valid && req_ready` is high. On acceptance, `req_*` is latched and `req_ready` falls.
- Address map:
  - Input port `IN_PORT_ADDR` = 11'h0FE is read-only.
  - Output port `OUT_PORT_ADDR` = 11'h0FF is write-only.
- Decode is done at acceptance. These go straight to RESP with `resp_err`=1, `resp_data`=0, and no bus strobe:
  - a read or poll to any address other than 0x0FE;
  - a write to any address other than 0x0FF;
  - op 11.
- Write: IDLE→WR→RESP. In WR, `write_en`=1, `in_addr`=addr and `in_data`=wdata for exactly one cycle.
- Read: IDLE→RD_ADDR→RD_SAMPLE→RESP.
  - RD_ADDR: `read_en`=1 and `in_addr`=addr. The port block registers the input at the end of this cycle.
  - RD_SAMPLE: `out_data` is captured into `resp_data` at the end of the cycle.
- Poll: read sequence repeated.
  - After each RD_SAMPLE, if `(out_data & mask) == (wdata & mask)`, go to RESP with `resp_err`=0.
  - Otherwise increment the attempt counter and return to RD_ADDR.
  - When the counter reaches `POLL_TIMEOUT`, go to RESP with `resp_err`=1 and `resp_data` = last sample.
- RESP: `resp_valid`=1 for one cycle, then IDLE. There is no response backpressure.
- `read_en` and `write_en` are never high together and are never high outside RD_ADDR/WR.
- `in_addr` and `in_data` hold their last driven values between cycles.

## Timing
- Reset values: `req_ready`=1 (IDLE), `read_en`=0, `write_en`=0, `in_addr`=0, `in_data`=0, `resp_valid`=0, `resp_data`=0, `resp_err`=0. Attempt counter = 0.
- All outputs are registered.
- Latency from the acceptance edge to the `resp_valid` cycle:
  - write: 2 cycles;
  - read: 3 cycles;
  - decode error: 1 cycle;
  - poll: 1 + 2·N cycles, where N is the number of read attempts.
- Back-to-back throughput: the next request is accepted in the cycle after RESP.
- `rst` asserted mid-operation: at that edge, the block drops strobes, goes to IDLE, and clears the counter. No response is issued for the aborted request.
- `req_valid` while not ready is ignored and not queued.
- Attempt counter width is clog2(POLL_TIMEOUT+1). It saturates and never wraps.

## Configuration
- `IO_BUS_MASTER_POLL_EN` defined: poll op supported as above; attempt counter is instantiated.
- Not defined: no counter logic. Op 10 is treated like op 11 (decode error, `resp_err`=1, no bus cycle).

## Structure
- Shared package `io_bus_pkg` holds:
  - `IN_PORT_ADDR` and `OUT_PORT_ADDR`;
  - default `DATA_W` and `ADDR_W`;
  - the `req_op` encoding constants;
  - the state enum typedef.
- The I/O port block uses the same address constants.
- One sub-module: `io_addr_decode`, a combinational legality check of op and address that outputs `legal`.
- All remaining logic is a single FSM inside `io_bus_master`.

## Test plan
- Write 0xC to 0x0FF → `write_en` high exactly one cycle with `in_data`=0xC; response `err`=0 two cycles after acceptance; port block `out_port`=0xC.
- `in_port`=0xC, read 0x0FE → `read_en` one cycle; `resp_data`=0xC, `err`=0 three cycles after acceptance. Then `in_port`=0x1, read again → 0x1.
- Read 0x0F8 and write 0xF to 0x0BF → `resp_err`=1 one cycle after acceptance, no strobes, `out_port` remains 0xC.
- Poll 0x0FE, mask 0x8, match 0x8; `in_port`=0x0 for 3 reads, then 0x9 → `resp_data`=0x9, `err`=0 after 4 attempts (9 cycles).
- POLL_TIMEOUT=4, `in_port` held at 0x0 → exactly 4 read strobes, `resp_err`=1, `resp_data`=0x0. Without the macro: same request → immediate error, no strobes.
- Assert `rst` during RD_SAMPLE → strobes 0 at the next edge, no `resp_valid`, `req_ready`=1; the next request completes normally.
